// File: rtl/stream_demux_n.sv
// Registered 1-to-CH valid/ready stream demux with explicit-select or round-robin routing.
// Optional per-channel saturating transfer counters when DEMUX_CNT_EN is defined.
module stream_demux_n #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  output logic [CH-1:0]         out_valid,
  input  logic [CH-1:0]         out_ready,
  output logic [CH*WIDTH-1:0]   out_data,
  output logic                  sel_err
`ifdef DEMUX_CNT_EN
  ,
  output logic [CH*16-1:0]      chan_cnt
`endif
);

  localparam logic [SEL_W:0]   CH_W    = (SEL_W+1)'(CH);
  localparam logic [SEL_W-1:0] RR_LAST = SEL_W'(CH-1);

  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;
  logic [SEL_W-1:0] hold_ch;
  logic [SEL_W-1:0] rr_ptr;
  logic             sel_err_q;

  logic [SEL_W-1:0] dest;
  logic             dest_ok;
  logic             accept;
  logic             drain;

  assign dest    = mode ? rr_ptr : in_sel;
  assign dest_ok = ({1'b0, dest} < CH_W);

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int i = 0; i < CH; i++) begin
      if (hold_valid && (hold_ch == SEL_W'(i))) begin
        out_valid[i]                = 1'b1;
        out_data[i*WIDTH +: WIDTH]  = hold_data;
      end
    end
  end

  // Only the lane carrying the held word can have out_valid set, so this picks its ready.
  assign drain    = |(out_valid & out_ready);
  assign in_ready = rst_n && (!hold_valid || drain);
  assign accept   = in_valid && in_ready;
  assign sel_err  = sel_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_ch    <= '0;
      rr_ptr     <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      sel_err_q <= accept && !dest_ok;
      if (accept && dest_ok) begin
        hold_valid <= 1'b1;
        hold_data  <= in_data;
        hold_ch    <= dest;
      end else if (drain || accept) begin
        hold_valid <= 1'b0;
      end
      if (accept && mode) begin
        rr_ptr <= (rr_ptr == RR_LAST) ? '0 : rr_ptr + SEL_W'(1);
      end
    end
  end

`ifdef DEMUX_CNT_EN
  logic [15:0] cnt_q [CH];

  for (genvar g = 0; g < CH; g++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q[g] <= '0;
      end else if (out_valid[g] && out_ready[g] && (cnt_q[g] != 16'hFFFF)) begin
        cnt_q[g] <= cnt_q[g] + 16'd1;
      end
    end
    assign chan_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule
